// File: rtl/alu_pkg.sv
// Shared definitions for the alu issue path: instruction-word layout,
// field offsets and a readable opcode type for waveforms.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int OPCODE_W  = 3;
    localparam int IW_W      = 2 * DATA_W + OPCODE_W + 1;

    // Bit offsets of each field inside the packed instruction word
    localparam int IW_B_LSB  = 0;
    localparam int IW_A_LSB  = DATA_W;
    localparam int IW_DT_BIT = 2 * DATA_W;
    localparam int IW_OP_LSB = 2 * DATA_W + 1;

    // The queue never decodes opcodes; names exist only to make traces readable
    typedef enum logic [OPCODE_W-1:0] {
        OPC_0 = 3'd0,
        OPC_1 = 3'd1,
        OPC_2 = 3'd2,
        OPC_3 = 3'd3,
        OPC_4 = 3'd4,
        OPC_5 = 3'd5,
        OPC_6 = 3'd6,
        OPC_7 = 3'd7
    } alu_opcode_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic                data_type;
        logic [DATA_W-1:0]   operand_a;
        logic [DATA_W-1:0]   operand_b;
    } alu_iw_t;

endpackage

// File: rtl/alu_iw_fifo.sv
// Generic circular FIFO of DEPTH instruction words. The occupancy counter
// separates full from empty, so the pointers can wrap freely.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// The head output reads as all-zero whenever the FIFO is empty.
module alu_iw_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Next occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage, written at the write pointer on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CNT_FULL);
            empty_r  <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign head      = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign occupancy = count_r;
    assign full      = full_r;
    assign empty     = empty_r;

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the combinational alu. Instructions are buffered
// in a circular FIFO, and the head is presented on alu_iw. The alu result is
// captured, tagged with its opcode, into a single result register that is
// drained through a valid/ready port.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPCODE_W-1:0]           in_opcode,
    input  logic                          in_data_type,
    input  logic [DATA_W-1:0]             in_operand_a,
    input  logic [DATA_W-1:0]             in_operand_b,
    output logic [2*DATA_W+OPCODE_W:0]    alu_iw,
    input  logic [DATA_W-1:0]             alu_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_W-1:0]             res_data,
    output logic [OPCODE_W-1:0]           res_opcode,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int IW_LEN = 2 * DATA_W + OPCODE_W + 1;

    logic [IW_LEN-1:0] push_iw_s;
    logic [IW_LEN-1:0] head_iw_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              capture_s;

    logic              res_valid_r;
    logic [DATA_W-1:0] res_data_r;
    alu_opcode_e       res_opcode_r;

    assign push_iw_s = {in_opcode, in_data_type, in_operand_a, in_operand_b};

    // Ready comes from the registered full flag only, so a pop in the same
    // cycle never lets a push through when the queue is full.
    assign in_ready  = ~fifo_full_s;
    assign push_s    = in_valid & ~fifo_full_s;

    // The head is consumed whenever the result register is free or is
    // being drained in this very cycle.
    assign capture_s = ~fifo_empty_s & (~res_valid_r | res_ready);

    alu_iw_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IW_LEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_iw_s),
        .pop       (capture_s),
        .head      (head_iw_s),
        .occupancy (occupancy),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // The FIFO already zeroes its head when empty
    assign alu_iw = head_iw_s;

    // Result register: capture alu_out on a pop, otherwise drain or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r  <= 1'b0;
            res_data_r   <= {DATA_W{1'b0}};
            res_opcode_r <= OPC_0;
        end else if (capture_s) begin
            res_valid_r  <= 1'b1;
            res_data_r   <= alu_out;
            res_opcode_r <= alu_opcode_e'(head_iw_s[IW_LEN-1 -: OPCODE_W]);
        end else if (res_ready && res_valid_r) begin
            res_valid_r  <= 1'b0;
            res_data_r   <= res_data_r;
            res_opcode_r <= res_opcode_r;
        end else begin
            res_valid_r  <= res_valid_r;
            res_data_r   <= res_data_r;
            res_opcode_r <= res_opcode_r;
        end
    end

    assign res_valid  = res_valid_r;
    assign res_data   = res_data_r;
    assign res_opcode = res_opcode_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue. A behavioural alu stand-in drives
// alu_out from alu_iw. The reference model is a queue of pending instructions
// plus one result slot, and a scoreboard holds the expected result stream.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int IWW   = 2 * DW + 4;

    logic           clk          = 1'b0;
    logic           rst_n        = 1'b0;
    logic           in_valid     = 1'b0;
    logic           in_ready;
    logic [2:0]     in_opcode    = 3'd0;
    logic           in_data_type = 1'b0;
    logic [DW-1:0]  in_operand_a = 32'd0;
    logic [DW-1:0]  in_operand_b = 32'd0;
    logic [IWW-1:0] alu_iw;
    logic [DW-1:0]  alu_out;
    logic           res_valid;
    logic           res_ready    = 1'b0;
    logic [DW-1:0]  res_data;
    logic [2:0]     res_opcode;
    logic [2:0]     occupancy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [IWW-1:0]  mq[$];
    bit              m_valid  = 1'b0;
    logic [DW-1:0]   m_data   = 32'd0;
    logic [2:0]      m_op     = 3'd0;
    bit              m_pushed = 1'b0;
    logic [DW+2:0]   exp_q[$];
    logic [DW+2:0]   got_q[$];

    // behavioural alu: op0 and, 1 or, 2 add, 3 sub, 4 xor, 5 shl, 6 shr, 7 less-than
    function automatic logic [DW-1:0] alu_ref(input logic [IWW-1:0] iw);
        logic [2:0]    op;
        logic          dt;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        op = iw[IWW-1 -: 3];
        dt = iw[2*DW];
        a  = iw[2*DW-1 -: DW];
        b  = iw[DW-1:0];
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return dt ? (a >> b[4:0]) : ($signed(a) >>> b[4:0]);
            3'd7: return dt ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_iw);

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_data_type (in_data_type),
        .in_operand_a (in_operand_a),
        .in_operand_b (in_operand_b),
        .alu_iw       (alu_iw),
        .alu_out      (alu_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_opcode   (res_opcode),
        .occupancy    (occupancy)
    );

    task automatic rand_in(input logic v);
        in_valid     = v;
        in_opcode    = 3'($urandom_range(0, 7));
        in_data_type = 1'($urandom_range(0, 1));
        in_operand_a = $urandom;
        in_operand_b = $urandom;
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        got_q.delete();
        m_valid  = 1'b0;
        m_pushed = 1'b0;
    endtask

    // Advance one clock from a falling edge to the next, updating the model
    task automatic step();
        bit             push_m;
        bit             cap_m;
        bit             fire_m;
        logic [IWW-1:0] iw;
        logic [IWW-1:0] hd;
        iw     = {in_opcode, in_data_type, in_operand_a, in_operand_b};
        push_m = in_valid && (mq.size() < DEPTH);
        fire_m = m_valid && res_ready;
        cap_m  = (mq.size() != 0) && (!m_valid || res_ready);
        if (res_valid && res_ready) got_q.push_back({res_opcode, res_data});
        @(posedge clk);
        if (cap_m) begin
            hd      = mq.pop_front();
            m_valid = 1'b1;
            m_op    = hd[IWW-1 -: 3];
            m_data  = alu_ref(hd);
        end else if (fire_m) begin
            m_valid = 1'b0;
        end
        if (push_m) begin
            mq.push_back(iw);
            exp_q.push_back({iw[IWW-1 -: 3], alu_ref(iw)});
        end
        m_pushed = push_m;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n         = 0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        while ((mq.size() != 0 || m_valid || res_valid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (res_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL drain_timeout res_valid=%0b occupancy=%0d want 0/0", res_valid, occupancy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (alu_iw !== 68'd0) begin errors++; $display("FAIL reset_alu_iw got %h want 0", alu_iw); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
        checks++; if (res_opcode !== 3'd0) begin errors++; $display("FAIL reset_res_opcode got %0d want 0", res_opcode); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_single();
        model_clear();
        res_ready    = 1'b1;
        in_valid     = 1'b1;
        in_opcode    = 3'b010;
        in_data_type = 1'b0;
        in_operand_a = 32'd1;
        in_operand_b = 32'd2;
        step();
        in_valid = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", res_valid); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occupancy got %0d want 1", occupancy); end
        checks++; if (alu_iw !== {3'b010, 1'b0, 32'd1, 32'd2}) begin errors++; $display("FAIL single_alu_iw got %h want %h", alu_iw, {3'b010, 1'b0, 32'd1, 32'd2}); end
        step();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid got %0b want 1", res_valid); end
        checks++; if (res_opcode !== 3'b010) begin errors++; $display("FAIL single_res_opcode got %0d want 2", res_opcode); end
        checks++; if (res_data !== 32'd3) begin errors++; $display("FAIL single_res_data got %0d want 3", res_data); end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got %0b want 0", res_valid); end
    endtask

    task automatic test_stream();
        model_clear();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_in(1'b1);
            step();
            checks++; if (occupancy > 3'd1) begin errors++; $display("FAIL stream_occupancy got %0d want <=1", occupancy); end
            checks++; if (res_valid !== (i >= 1)) begin errors++; $display("FAIL stream_res_valid cycle %0d got %0b want %0b", i, res_valid, (i >= 1)); end
        end
        drain(20);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stream_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_order idx %0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_fill();
        int accepted;
        int n;
        model_clear();
        res_ready = 1'b0;
        accepted  = 0;
        n         = 0;
        rand_in(1'b1);
        while (accepted < 5 && n < 20) begin
            checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL fill_in_ready got %0b want %0b", in_ready, (mq.size() != DEPTH)); end
            step();
            n++;
            if (m_pushed) begin
                accepted++;
                rand_in(1'b1);
            end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b want 0", in_ready); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occupancy got %0d want 4", occupancy); end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL fill_res_valid got %0b want 1", res_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (in_ready !== 1'b0 || occupancy !== 3'd4) begin errors++; $display("FAIL fill_held ready=%0b occ=%0d want 0/4", in_ready, occupancy); end
        end
        res_ready = 1'b1;
        n = 0;
        while (accepted < 6 && n < 20) begin
            step();
            n++;
            if (m_pushed) accepted++;
        end
        drain(30);
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL fill_count got %0d want 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_order idx %0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_hold();
        model_clear();
        res_ready = 1'b0;
        rand_in(1'b1);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %0b want 1", res_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({res_opcode, res_data} !== exp_q[0]) begin errors++; $display("FAIL hold_stable cycle %0d got %h want %h", i, {res_opcode, res_data}, exp_q[0]); end
        end
        drain(10);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL hold_count got %0d want 1", got_q.size()); end
    endtask

    task automatic test_wrap();
        int accepted;
        int n;
        model_clear();
        accepted = 0;
        n        = 0;
        while (accepted < 3 * DEPTH && n < 300) begin
            rand_in($urandom_range(0, 3) != 0);
            res_ready = 1'($urandom_range(0, 1));
            checks++; if (occupancy !== 3'(mq.size())) begin errors++; $display("FAIL wrap_occupancy got %0d want %0d", occupancy, mq.size()); end
            checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL wrap_in_ready got %0b want %0b", in_ready, (mq.size() != DEPTH)); end
            checks++; if (res_valid !== m_valid) begin errors++; $display("FAIL wrap_res_valid got %0b want %0b", res_valid, m_valid); end
            if (m_valid) begin
                checks++; if (res_data !== m_data || res_opcode !== m_op) begin errors++; $display("FAIL wrap_result got %0d/%h want %0d/%h", res_opcode, res_data, m_op, m_data); end
            end
            step();
            n++;
            if (m_pushed) accepted++;
        end
        drain(30);
        checks++; if (got_q.size() != 3 * DEPTH) begin errors++; $display("FAIL wrap_count got %0d want %0d", got_q.size(), 3 * DEPTH); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order idx %0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        model_clear();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b1);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got %0b want 0", res_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL midrst_occupancy got %0d want 0", occupancy); end
        checks++; if (alu_iw !== 68'd0) begin errors++; $display("FAIL midrst_alu_iw got %h want 0", alu_iw); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        rand_in(1'b1);
        step();
        drain(10);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midrst_count got %0d want 1", got_q.size()); end
        if (got_q.size() == 1 && exp_q.size() == 1) begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_result got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_fill();
        test_hold();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
